icache_direct_mapped: RTL and testbench

//  Direct-mapped, read-only instruction cache between the CPU fetch port (PC) and instruction memory.

---
 rtl/icache_direct_mapped.sv | 102 ++++++++++
 tb/tb_icache_direct_mapped.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/icache_direct_mapped.sv
// icache_direct_mapped: direct-mapped read-only instruction cache with 128-bit block refill.
// Optional hit/miss counters are enabled by defining ICACHE_STATS_EN.
module icache_direct_mapped #(
    parameter int ADDR_WIDTH   = 10,
    parameter int INDEX_WIDTH  = 3,
    parameter int OFFSET_WIDTH = 4
) (
    input  logic                               CLK,
    input  logic                               RESET,
    input  logic                               READ,
    input  logic [ADDR_WIDTH-1:0]              ADDRESS,
    output logic [31:0]                        INSTRUCTION,
    output logic                               BUSYWAIT,
    output logic                               MEM_READ,
    output logic [ADDR_WIDTH-OFFSET_WIDTH-1:0] MEM_ADDRESS,
    input  logic [127:0]                       MEM_READDATA,
    input  logic                               MEM_BUSYWAIT
`ifdef ICACHE_STATS_EN
    ,
    output logic [15:0]                        HIT_COUNT,
    output logic [15:0]                        MISS_COUNT
`endif
);
    localparam int TAG_WIDTH = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH;
    localparam int LINES     = 1 << INDEX_WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_MEM_READ, S_UPDATE} state_t;

    state_t                        state, next_state;
    logic [LINES-1:0]              valid;
    logic [TAG_WIDTH-1:0]          tag_array [LINES];
    logic [127:0]                  data_array [LINES];
    logic [TAG_WIDTH-1:0]          tag, lat_tag;
    logic [INDEX_WIDTH-1:0]        index, lat_index;
    logic [OFFSET_WIDTH-3:0]       word;
    logic [31:0]                   word_data, instr_q;
    logic                          hit, miss, fill;
    logic                          unused;

    assign tag       = ADDRESS[ADDR_WIDTH-1 -: TAG_WIDTH];
    assign index     = ADDRESS[OFFSET_WIDTH +: INDEX_WIDTH];
    assign word      = ADDRESS[OFFSET_WIDTH-1:2];
    assign unused    = &{1'b0, ADDRESS[1:0]};
    assign word_data = data_array[index][{word, 5'd0} +: 32];
    assign hit       = READ & valid[index] & (tag_array[index] == tag);
    assign miss      = READ & ~hit;
    assign fill      = (state == S_MEM_READ) & ~MEM_BUSYWAIT;

    always_ff @(posedge CLK) begin
        if (RESET) state <= S_IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = (state == S_IDLE)     ? (miss ? S_MEM_READ : S_IDLE) :
                     (state == S_MEM_READ) ? (MEM_BUSYWAIT ? S_MEM_READ : S_UPDATE) :
                                             S_IDLE;
    end

    always_comb begin
        MEM_READ    = (state == S_MEM_READ);
        MEM_ADDRESS = MEM_READ ? {lat_tag, lat_index} : '0;
        BUSYWAIT    = (state != S_IDLE) | miss;
        INSTRUCTION = ((state == S_IDLE) && hit) ? word_data : instr_q;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            valid     <= '0;
            instr_q   <= '0;
            lat_tag   <= '0;
            lat_index <= '0;
        end else begin
            if ((state == S_IDLE) && hit) instr_q <= word_data;
            if ((state == S_IDLE) && miss) begin
                lat_tag   <= tag;
                lat_index <= index;
            end
            if (fill) valid[lat_index] <= 1'b1;
        end
    end

    // Tag/data storage is deliberately left uncleared by reset; valid bits guard it.
    always_ff @(posedge CLK) begin
        if (fill && !RESET) begin
            data_array[lat_index] <= MEM_READDATA;
            tag_array[lat_index]  <= lat_tag;
        end
    end

`ifdef ICACHE_STATS_EN
    always_ff @(posedge CLK) begin
        if (RESET) begin
            HIT_COUNT  <= '0;
            MISS_COUNT <= '0;
        end else begin
            if ((state == S_IDLE) && hit && (HIT_COUNT != 16'hFFFF)) HIT_COUNT <= HIT_COUNT + 16'd1;
            if ((state == S_IDLE) && miss && (MISS_COUNT != 16'hFFFF)) MISS_COUNT <= MISS_COUNT + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_icache_direct_mapped.sv
// tb_icache_direct_mapped: directed and random fetches against a block-address reference model.
module tb_icache_direct_mapped;
    logic         CLK = 1'b0;
    logic         RESET = 1'b1;
    logic         READ = 1'b0;
    logic [9:0]   ADDRESS = '0;
    logic [31:0]  INSTRUCTION;
    logic         BUSYWAIT;
    logic         MEM_READ;
    logic [5:0]   MEM_ADDRESS;
    logic [127:0] MEM_READDATA = '0;
    logic         MEM_BUSYWAIT = 1'b0;
`ifdef ICACHE_STATS_EN
    logic [15:0]  HIT_COUNT, MISS_COUNT;
`endif

    icache_direct_mapped dut (
        .CLK(CLK), .RESET(RESET), .READ(READ), .ADDRESS(ADDRESS),
        .INSTRUCTION(INSTRUCTION), .BUSYWAIT(BUSYWAIT), .MEM_READ(MEM_READ),
        .MEM_ADDRESS(MEM_ADDRESS), .MEM_READDATA(MEM_READDATA), .MEM_BUSYWAIT(MEM_BUSYWAIT)
`ifdef ICACHE_STATS_EN
        , .HIT_COUNT(HIT_COUNT), .MISS_COUNT(MISS_COUNT)
`endif
    );

    always #5 CLK = ~CLK;

    int          checks = 0;
    int          errors = 0;
    int          cached [8];
    int          exp_hits, exp_misses;
    logic [31:0] last_instr;

    // Memory image: each word holds its own byte address.
    function automatic logic [127:0] block_data(input int b);
        logic [127:0] d;
        for (int w = 0; w < 4; w++) d[32*w +: 32] = 32'(b * 16 + 4 * w);
        return d;
    endfunction

    task automatic chk(input string t, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", t, o, e);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) cached[i] = -1;
        exp_hits = 0;
        exp_misses = 0;
        last_instr = '0;
    endtask

    task automatic do_reset();
        @(posedge CLK); #1;
        RESET = 1'b1; READ = 1'b0; MEM_BUSYWAIT = 1'b0;
        @(posedge CLK); #1;
        RESET = 1'b0;
        model_reset();
        @(negedge CLK);
        chk("rst_busywait", 32'(BUSYWAIT), 0);
        chk("rst_mem_read", 32'(MEM_READ), 0);
        chk("rst_mem_address", 32'(MEM_ADDRESS), 0);
        chk("rst_instruction", INSTRUCTION, 0);
    endtask

    task automatic idle();
        @(posedge CLK); #1;
        READ = 1'b0; ADDRESS = 10'($urandom); MEM_BUSYWAIT = 1'($urandom);
        @(negedge CLK);
        chk("idle_busywait", 32'(BUSYWAIT), 0);
        chk("idle_mem_read", 32'(MEM_READ), 0);
        chk("idle_instruction", INSTRUCTION, last_instr);
    endtask

    task automatic fetch(input logic [9:0] a, input int nbusy, input logic [9:0] alt);
        int b;
        b = int'(a[9:4]);
        @(posedge CLK); #1;
        READ = 1'b1; ADDRESS = a; MEM_BUSYWAIT = 1'b0;
        @(negedge CLK);
        if (cached[b % 8] == b) begin
            chk("hit_busywait", 32'(BUSYWAIT), 0);
            chk("hit_mem_read", 32'(MEM_READ), 0);
            chk("hit_instruction", INSTRUCTION, 32'(a & 10'h3FC));
        end else begin
            chk("miss_busywait", 32'(BUSYWAIT), 1);
            exp_misses++;
            @(posedge CLK); #1;
            for (int i = 0; i < nbusy; i++) begin
                MEM_BUSYWAIT = 1'b1; MEM_READDATA = {4{$urandom}}; ADDRESS = alt;
                @(negedge CLK);
                chk("busy_mem_read", 32'(MEM_READ), 1);
                chk("busy_mem_address", 32'(MEM_ADDRESS), 32'(b));
                chk("busy_busywait", 32'(BUSYWAIT), 1);
                @(posedge CLK); #1;
            end
            MEM_BUSYWAIT = 1'b0; MEM_READDATA = block_data(b); ADDRESS = alt;
            @(negedge CLK);
            chk("fill_mem_read", 32'(MEM_READ), 1);
            chk("fill_mem_address", 32'(MEM_ADDRESS), 32'(b));
            @(posedge CLK); #1;
            cached[b % 8] = b;
            MEM_BUSYWAIT = 1'($urandom); MEM_READDATA = {4{$urandom}}; ADDRESS = a;
            @(negedge CLK);
            chk("update_busywait", 32'(BUSYWAIT), 1);
            chk("update_mem_read", 32'(MEM_READ), 0);
            @(posedge CLK); #1;
            MEM_BUSYWAIT = 1'b0;
            @(negedge CLK);
            chk("post_fill_busywait", 32'(BUSYWAIT), 0);
            chk("post_fill_instruction", INSTRUCTION, 32'(a & 10'h3FC));
        end
        exp_hits++;
        last_instr = 32'(a & 10'h3FC);
    endtask

    task automatic chk_stats();
`ifdef ICACHE_STATS_EN
        chk("hit_count", 32'(HIT_COUNT), 32'(exp_hits));
        chk("miss_count", 32'(MISS_COUNT), 32'(exp_misses));
`endif
    endtask

    initial begin
        int b;
        logic [9:0] a;
        model_reset();
        do_reset();
        // cold miss with a 5-cycle memory, then sequential hits in the same block
        fetch(10'h000, 5, 10'h000);
        fetch(10'h004, 0, 10'h000);
        fetch(10'h008, 0, 10'h000);
        fetch(10'h00C, 0, 10'h000);
        idle();
        chk_stats();
        // conflict on line 0, then the original block misses again
        fetch(10'h080, 2, 10'h000);
        fetch(10'h000, 1, 10'h000);
        // address wanders during refill; latched block must still be fetched
        fetch(10'h010, 3, 10'h3F0);
        fetch(10'h014, 0, 10'h000);
        idle();
        chk_stats();
        // reset in the middle of a refill
        @(posedge CLK); #1;
        READ = 1'b1; ADDRESS = 10'h3F0;
        @(posedge CLK); #1;
        MEM_BUSYWAIT = 1'b1;
        @(negedge CLK);
        chk("midmiss_mem_read", 32'(MEM_READ), 1);
        @(posedge CLK); #1;
        RESET = 1'b1; READ = 1'b0; MEM_BUSYWAIT = 1'b0; MEM_READDATA = block_data(63);
        @(posedge CLK); #1;
        @(negedge CLK);
        chk("rstmiss_mem_read", 32'(MEM_READ), 0);
        chk("rstmiss_busywait", 32'(BUSYWAIT), 0);
        @(posedge CLK); #1;
        RESET = 1'b0;
        model_reset();
        idle();
        chk_stats();
        fetch(10'h000, 2, 10'h155);
        fetch(10'h3F4, 1, 10'h000);
        // random traffic over a small pool of blocks so lines conflict and hit
        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 3) == 0) idle();
            else begin
                b = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 15));
                a = {6'(b), 4'($urandom)};
                fetch(a, int'($urandom_range(0, 4)), 10'($urandom));
            end
        end
        idle();
        chk_stats();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
